// File: rtl/imem_loader.sv
// Serial instruction-memory loader: count byte, N big-endian 16-bit words, XOR checksum byte.
// Holds the CPU until a session ends in DONE; words already written are never rolled back.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_len;
  logic [IW-1:0]     w_idx_inc;
  logic [7:0]        r_csum;
  logic [15:0]       r_wdata;
  logic [ADDR_W-1:0] r_adr;
  logic              w_acc;
  logic              w_start;
  logic              w_len_bad;

  assign w_acc     = in_valid & in_ready;
  assign w_start   = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_len_bad = (in_data == 8'd0) || (32'(in_data) > DEPTH);
  assign w_idx_inc = r_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_next = S_LEN;
      S_LEN:   if (w_acc) w_next = w_len_bad ? S_ERR : S_HI;
      S_HI:    if (w_acc) w_next = S_LO;
      S_LO:    if (w_acc) w_next = S_WRITE;
      S_WRITE: w_next = (w_idx_inc == r_len) ? S_CHK : S_HI;
      S_CHK:   if (w_acc) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    case (r_state)
      S_LEN, S_HI, S_LO, S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Address is captured with the low byte so it stays stable through and after the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_csum  <= '0;
      r_wdata <= '0;
      r_adr   <= '0;
    end else begin
      if (w_start) begin
        r_idx  <= '0;
        r_csum <= '0;
      end
      if (r_state == S_LEN && w_acc && !w_len_bad) r_len <= IW'(in_data);
      if (r_state == S_HI && w_acc) begin
        r_wdata[15:8] <= in_data;
        r_csum        <= r_csum ^ in_data;
      end
      if (r_state == S_LO && w_acc) begin
        r_wdata[7:0] <= in_data;
        r_csum       <= r_csum ^ in_data;
        r_adr        <= ADDR_W'(r_idx);
      end
      if (r_state == S_WRITE) r_idx <= w_idx_inc;
    end
  end

  assign mem_adr   = r_adr;
  assign mem_wdata = r_wdata;

endmodule
